// File: rtl/logs_freq_meter.sv
// logs_freq_meter: counts rising edges of snd_in over 2^W step pulses and
// rescales the count to an NCO frequency word (step rate / 2^N units).
// Ports: clk, reset (sync, active-high), step (count enable), snd_in (wave
// under test), start, continuous; busy, valid (1-cycle), freq_out[N-2:0],
// sat (result clipped to 2^(N-1)-1).
module logs_freq_meter #(
   parameter int N    = 5,
   parameter int W    = 8,
   parameter int SYNC = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         step,
   input  logic         snd_in,
   input  logic         start,
   input  logic         continuous,
   output logic         busy,
   output logic         valid,
   output logic [N-2:0] freq_out,
   output logic         sat
);

   localparam int CW = W + 1;
   localparam int SH = W - N;
   localparam logic [CW-1:0] WIN  = CW'(2 ** W);
   localparam logic [CW-1:0] HALF = CW'(2 ** (W - N - 1));
   localparam logic [N:0]    FMAX = (N+1)'(2 ** (N - 1) - 1);

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      GATE,
      REPORT
   } state_t;

   state_t         state_q, state_d;
   logic           prev_q, prev_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [CW-1:0]  win_q, win_d;
   logic [N-2:0]   freq_q, freq_d;
   logic           sat_q, sat_d;

   logic           s;
   logic           rise;
   logic [CW-1:0]  cnt_inc;
   logic [CW-1:0]  win_inc;
   logic [N:0]     raw;
   logic           res_sat;
   logic [N-2:0]   res_freq;

   // Optional two-flop synchronizer; runs every clk, independent of step.
   if (SYNC == 2) begin : g_sync
      logic [1:0] sync_q;
      always_ff @(posedge clk) begin
         if (reset) begin
            sync_q <= '0;
         end else begin
            sync_q <= {sync_q[0], snd_in};
         end
      end
      assign s = sync_q[1];
   end else begin : g_nosync
      assign s = snd_in;
   end

   assign rise    = s & ~prev_q;
   assign cnt_inc = cnt_q + CW'(rise);
   assign win_inc = win_q + CW'(1);

   // Round half-up before dropping the W-N window bits; the final count
   // includes the edge seen on the last step of the window.
   assign raw      = (N+1)'((cnt_inc + HALF) >> SH);
   assign res_sat  = (raw > FMAX);
   assign res_freq = res_sat ? '1 : raw[N-2:0];

   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      cnt_d   = cnt_q;
      win_d   = win_q;
      freq_d  = freq_q;
      sat_d   = sat_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ARM;
            end
         end
         ARM: begin
            if (step) begin
               prev_d  = s;
               cnt_d   = '0;
               win_d   = '0;
               state_d = GATE;
            end
         end
         GATE: begin
            if (step) begin
               prev_d = s;
               cnt_d  = cnt_inc;
               win_d  = win_inc;
               if (win_inc == WIN) begin
                  freq_d  = res_freq;
                  sat_d   = res_sat;
                  state_d = REPORT;
               end
            end
         end
         REPORT: begin
            if (continuous) begin
               // prev carries over so windows tile seamlessly; a step
               // here is the first step of the next window.
               state_d = GATE;
               if (step) begin
                  prev_d = s;
                  cnt_d  = CW'(rise);
                  win_d  = CW'(1);
               end else begin
                  cnt_d  = '0;
                  win_d  = '0;
               end
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         prev_q  <= 1'b0;
         cnt_q   <= '0;
         win_q   <= '0;
         freq_q  <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         cnt_q   <= cnt_d;
         win_q   <= win_d;
         freq_q  <= freq_d;
         sat_q   <= sat_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign valid    = (state_q == REPORT);
   assign freq_out = freq_q;
   assign sat      = sat_q;

endmodule

// File: tb/tb_logs_freq_meter.sv
// tb_logs_freq_meter: random-stimulus bench for logs_freq_meter (SYNC 0/2).
// Expected results come from edge counts over recorded per-step levels.
module tb_logs_freq_meter;

   localparam int N  = 5;
   localparam int W  = 8;
   localparam int WL = 1 << W;

   logic         clk = 1'b0;
   logic         reset, step, snd_in, start, continuous;
   logic         busy0, valid0, sat0, busy2, valid2, sat2;
   logic [N-2:0] fo0, fo2;

   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   logic hist [0:65535];
   logic [N-1:0] ph;
   logic tg;

   always #5 clk = ~clk;

   logs_freq_meter #(.N(N), .W(W), .SYNC(0)) u_dut0 (
      .clk(clk), .reset(reset), .step(step), .snd_in(snd_in),
      .start(start), .continuous(continuous), .busy(busy0),
      .valid(valid0), .freq_out(fo0), .sat(sat0)
   );

   logs_freq_meter #(.N(N), .W(W), .SYNC(2)) u_dut2 (
      .clk(clk), .reset(reset), .step(step), .snd_in(snd_in),
      .start(start), .continuous(continuous), .busy(busy2),
      .valid(valid2), .freq_out(fo2), .sat(sat2)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic void expect_res(input int cnt, output int f,
                                      output int s);
      int raw;
      raw = (cnt + (1 << (W - N - 1))) >> (W - N);
      if (raw > (1 << (N - 1)) - 1) begin
         f = (1 << (N - 1)) - 1;
         s = 1;
      end else begin
         f = raw;
         s = 0;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         start      = 1'b0;
         step       = 1'b0;
         continuous = 1'b0;
         snd_in     = 1'b0;
         hist[cyc]  = 1'b0;
      end
   endtask

   // kind: 0 NCO(f), 1 hold 0, 2 hold 1, 3 toggle per step, 4 random.
   // sper: step every sper clks, 0 = random steps. want<0: no fixed value.
   task automatic run_case(input string tag, input int kind, input int f,
                           input int sper, input int nrep, input bit rnd,
                           input int want);
      int   sc[$];
      logic lv0[$];
      logic lv2[$];
      int   vc0[$], vf0[$], vs0[$], vc2[$], vf2[$], vs2[$];
      int   lim, post, ef, es, cnt0, cnt2, ecyc, lastf;
      bit   off, lastv;
      lim   = (sper == 0 ? 4 : sper) * WL * (nrep + 1) + 100;
      ph    = '0;
      tg    = 1'b0;
      off   = 1'b0;
      lastv = 1'b0;
      post  = 0;
      for (int i = 0; i < lim && post < 5; i++) begin
         tick();
         if (valid0) begin
            vc0.push_back(cyc);
            vf0.push_back(int'(fo0));
            vs0.push_back(int'(sat0));
            chk({tag, "_busy_rep"}, int'(busy0), 1);
         end
         if (valid2) begin
            vc2.push_back(cyc);
            vf2.push_back(int'(fo2));
            vs2.push_back(int'(sat2));
         end
         if (lastv && !valid0 && vc0.size() == nrep) begin
            chk({tag, "_busy_drop0"}, int'(busy0), 0);
            chk({tag, "_busy_drop2"}, int'(busy2), 0);
         end
         lastv = valid0;
         if (vc0.size() >= nrep) post++;
         if (vc0.size() >= nrep - 1 && !valid0) off = 1'b1;
         start = (i == 0) ||
                 (rnd && busy0 && !valid0 && $urandom_range(0, 7) == 0);
         continuous = (nrep > 1) && !off;
         if (sper == 0) step = 1'($urandom_range(0, 1));
         else           step = ((i % sper) == 0);
         case (kind)
            0:       snd_in = ph[N-1];
            1:       snd_in = 1'b0;
            2:       snd_in = 1'b1;
            3:       snd_in = tg;
            default: snd_in = 1'($urandom_range(0, 1));
         endcase
         hist[cyc] = snd_in;
         if (i > 0 && step) begin
            sc.push_back(cyc);
            lv0.push_back(snd_in);
            lv2.push_back(hist[cyc-2]);
         end
         if (step) begin
            ph = ph + f[N-1:0];
            tg = ~tg;
         end
      end
      chk({tag, "_nrep0"}, vc0.size(), nrep);
      chk({tag, "_nrep2"}, vc2.size(), nrep);
      lastf = -1;
      for (int k = 1; k <= nrep; k++) begin
         if (sc.size() < k * WL + 1) begin
            chk({tag, "_steps"}, sc.size(), k * WL + 1);
            break;
         end
         ecyc = sc[k*WL] + 1;
         cnt0 = 0;
         cnt2 = 0;
         for (int j = (k - 1) * WL + 1; j <= k * WL; j++) begin
            cnt0 += int'(lv0[j] && !lv0[j-1]);
            cnt2 += int'(lv2[j] && !lv2[j-1]);
         end
         expect_res(cnt0, ef, es);
         lastf = ef;
         if (k <= vc0.size()) begin
            chk({tag, "_cyc0"}, vc0[k-1], ecyc);
            chk({tag, "_freq0"}, vf0[k-1], ef);
            chk({tag, "_sat0"}, vs0[k-1], es);
            if (want >= 0) chk({tag, "_want0"}, vf0[k-1], want);
         end
         expect_res(cnt2, ef, es);
         if (k <= vc2.size()) begin
            chk({tag, "_cyc2"}, vc2[k-1], ecyc);
            chk({tag, "_freq2"}, vf2[k-1], ef);
            chk({tag, "_sat2"}, vs2[k-1], es);
            if (want >= 0) chk({tag, "_want2"}, vf2[k-1], want);
         end
      end
      if (lastf >= 0) chk({tag, "_held0"}, int'(fo0), lastf);
      chk({tag, "_idle0"}, int'(busy0), 0);
      idle(4);
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      step       = 1'b0;
      continuous = 1'b0;
      snd_in     = 1'b0;
      idle(3);
      chk("rst_busy", int'(busy0), 0);
      chk("rst_valid", int'(valid0), 0);
      chk("rst_freq", int'(fo0), 0);
      chk("rst_sat", int'(sat0), 0);
      chk("rst_busy2", int'(busy2), 0);
      reset = 1'b0;
      idle(4);

      run_case("nco3", 0, 3, 1, 1, 1'b0, 3);
      run_case("hold0", 1, 0, 1, 1, 1'b0, 0);
      run_case("hold1", 2, 0, 1, 1, 1'b0, 0);
      run_case("toggle", 3, 0, 1, 1, 1'b0, 15);
      run_case("cont5", 0, 5, 3, 3, 1'b1, 5);

      for (int i = 0; i < 100; i++) begin
         tick();
         start      = (i == 0);
         step       = 1'b1;
         continuous = 1'b0;
         snd_in     = 1'($urandom_range(0, 1));
         hist[cyc]  = snd_in;
      end
      tick();
      chk("rst_busy_pre", int'(busy0), 1);
      reset     = 1'b1;
      snd_in    = 1'b0;
      hist[cyc] = 1'b0;
      tick();
      chk("midrst_busy", int'(busy0), 0);
      chk("midrst_valid", int'(valid0), 0);
      chk("midrst_freq", int'(fo0), 0);
      chk("midrst_sat", int'(sat0), 0);
      chk("midrst_busy2", int'(busy2), 0);
      chk("midrst_freq2", int'(fo2), 0);
      reset     = 1'b0;
      hist[cyc] = 1'b0;
      idle(4);
      run_case("post_rst", 0, 7, 1, 1, 1'b1, 7);

      for (int r = 0; r < 6; r++) begin
         int kind, f, sp, nr;
         kind = ($urandom_range(0, 1) == 0) ? 0 : 4;
         f    = $urandom_range(0, 15);
         sp   = $urandom_range(0, 2);
         nr   = $urandom_range(1, 2);
         run_case($sformatf("rnd%0d", r), kind, f, sp, nr, 1'b1,
                  (kind == 0) ? f : -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/logs_freq_meter.md
Name: logs_freq_meter

Overview:
- Frequency meter for the square waves produced by the logs NCO bank.
- Counts rising edges of `snd_in` over a gate window of exactly 2^W step pulses.
- Rescales the count into the NCO's frequency-word units: [step rate] / 2^N.
- Used in self-test to read back an oscillator's `freq_in`; can run one-shot or continuous.

Parameters:
- N, 5: phase-accumulator width of the measured NCO; output word is N-1 bits.
- W, 8: log2 of gate window length in step pulses; legal range W >= N+1.
- SYNC, 0: number of input synchronizer flops, 0 or 2. Use 2 if `snd_in` comes from another clock domain.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- step  in  1  sample/count enable (same strobe that steps the NCO)
- snd_in  in  1  square wave under test
- start  in  1  begin measurement; sampled only in IDLE
- continuous  in  1  1 = re-arm a new window automatically after each report
- busy  out  1  high whenever state != IDLE
- valid  out  1  one-cycle pulse: new result on freq_out/sat
- freq_out  out  N-1  measured frequency word, held until the next report
- sat  out  1  result saturated; held with freq_out

Behaviour:
- Reset: state IDLE; busy=0, valid=0, freq_out=0, sat=0; edge count, window count and prev-level flop all cleared.
- Reset mid-measurement aborts with no report; reset has priority over every other input.
- Input path:
  - SYNC=2: `snd_in` passes through two flops clocked every clk, regardless of step.
  - SYNC=0: `snd_in` is used directly.
  - Call the result `s`.
- State IDLE:
  - start=1 -> ARM on the next cycle.
  - start=0 -> stay in IDLE.
- State ARM:
  - Waits for the first cycle with step=1.
  - On that cycle: prev <= s, edge count <= 0, window count <= 0, go to GATE.
  - No edge is counted in ARM.
- State GATE, on each cycle with step=1:
  - prev <= s.
  - If s=1 and prev=0, edge count += 1.
  - window count += 1.
  - Cycles with step=0 change nothing.
- End of window:
  - On the step cycle where window count reaches 2^W (the 2^W-th step in GATE), the final count includes that cycle's edge.
  - The result is registered and the FSM goes to REPORT.
- Counter widths:
  - Edge count is W+1 bits and cannot wrap; max 2^W edges.
  - Window count is W+1 bits, or W bits with a terminal-count flag.
- Result arithmetic:
  - raw = (count + 2^(W-N-1)) >> (W-N), i.e. round-half-up.
  - If raw > 2^(N-1)-1: freq_out = 2^(N-1)-1 and sat = 1.
  - Otherwise freq_out = raw and sat = 0.
- State REPORT (exactly one cycle):
  - valid=1; freq_out and sat already show the new values.
  - continuous=1 -> GATE with edge and window counts cleared. prev is retained and is not re-armed.
  - A step in the REPORT cycle is processed as the first step of the new window, including edge detection against prev.
  - continuous=0 -> IDLE; any step in this cycle is ignored.
- Latency: valid rises on the clk edge after the final step cycle of the window.
- In continuous mode, consecutive windows tile with no lost step pulses.
- `start` is ignored outside IDLE. Clearing `continuous` mid-window takes effect at the next REPORT.
- valid is never asserted outside REPORT. freq_out and sat change only on entry to REPORT and on reset.

Test Plan:
- Driven by a logs_nco instance, N=5, W=8, freq_in=3, step=1 every clk, one-shot start:
  - count is 24 ±1;
  - valid pulses once, 1 cycle after the 256th GATE step;
  - freq_out=3, sat=0, busy drops the same cycle as valid.
- snd_in held 0, then held 1 for a full window -> freq_out=0, sat=0 in both cases.
- snd_in toggling every step (128 edges) -> raw=16 -> freq_out=15, sat=1.
- step asserted every 3rd clk, NCO freq_in=5, continuous=1:
  - freq_out=5 on every report;
  - valid pulses spaced exactly 3*256 clks apart (excluding the first);
  - no step pulse is lost between windows.
- Reset asserted mid-GATE:
  - next cycle: busy=0, valid=0, freq_out=0;
  - a later start yields a fresh, correct result.
- start pulsed while busy -> ignored; SYNC=2 build gives the same results as the first scenario with valid shifted 2 cycles or less.
